// File: rtl/mips_mem_system.sv
// Unified RAM plus memory-mapped LED, cycle counter and UART transmitter for the
// multicycle MIPS core. Reads are combinational and writes commit in one cycle.
module mips_mem_system #(
  parameter int RAM_WORDS = 256,
  parameter int CLK_DIV   = 16
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_wr_ena,
  output logic [31:0] mem_rd_data,
  output logic [7:0]  leds,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  logic [31:0]    r_ram [RAM_WORDS];
  logic [7:0]     r_leds;
  logic [31:0]    r_cycle;

  uart_state_t    r_state, w_state_n;
  logic [TW-1:0]  r_timer, w_timer_n;
  logic [2:0]     r_bit_idx, w_bit_idx_n;
  logic [7:0]     r_shift, w_shift_n;
  logic           r_tx, w_tx_n;

  logic [29:0]    w_word;
  logic [AW-1:0]  w_ram_idx;
  logic           w_is_ram, w_is_led, w_is_cycle, w_is_tx, w_is_stat;
  logic           w_busy, w_accept;
  logic           w_unused;

  // Byte offset is irrelevant: every access is a whole word.
  assign w_unused   = &{1'b0, mem_addr[1:0]};
  assign w_word     = mem_addr[31:2];
  assign w_ram_idx  = mem_addr[AW+1:2];
  assign w_is_ram   = (mem_addr[31:AW+2] == '0);
  assign w_is_led   = (w_word == 30'h3FFF_C000);
  assign w_is_cycle = (w_word == 30'h3FFF_C001);
  assign w_is_tx    = (w_word == 30'h3FFF_C002);
  assign w_is_stat  = (w_word == 30'h3FFF_C003);

  assign w_busy   = (r_state != IDLE);
  assign w_accept = mem_wr_ena && w_is_tx && !w_busy;

  assign leds    = r_leds;
  assign uart_tx = r_tx;

  always_ff @(posedge clk) begin
    if (mem_wr_ena && w_is_ram) r_ram[w_ram_idx] <= mem_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_leds <= 8'h00;
    end else if (mem_wr_ena && w_is_led) begin
      r_leds <= mem_wr_data[7:0];
    end
  end

  // A write restarts the count so the next read sees 0; it beats the increment.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_cycle <= 32'h0;
    end else if (mem_wr_ena && w_is_cycle) begin
      r_cycle <= 32'h0;
    end else begin
      r_cycle <= r_cycle + 32'h1;
    end
  end

  always_comb begin
    mem_rd_data = 32'h0;
    if (w_is_ram)        mem_rd_data = r_ram[w_ram_idx];
    else if (w_is_led)   mem_rd_data = {24'h0, r_leds};
    else if (w_is_cycle) mem_rd_data = r_cycle;
    else if (w_is_stat)  mem_rd_data = {31'h0, w_busy};
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_n;
      r_timer   <= w_timer_n;
      r_bit_idx <= w_bit_idx_n;
      r_shift   <= w_shift_n;
      r_tx      <= w_tx_n;
    end
  end

  // uart_tx is registered: the line value for a state is loaded on the edge
  // that enters it, so the start bit appears right after the accepting write.
  always_comb begin
    w_state_n   = r_state;
    w_timer_n   = r_timer;
    w_bit_idx_n = r_bit_idx;
    w_shift_n   = r_shift;
    w_tx_n      = r_tx;
    case (r_state)
      IDLE: begin
        w_tx_n = 1'b1;
        if (w_accept) begin
          w_state_n   = START;
          w_timer_n   = '0;
          w_bit_idx_n = 3'd0;
          w_shift_n   = mem_wr_data[7:0];
          w_tx_n      = 1'b0;
        end
      end
      START: begin
        if (r_timer == TMAX) begin
          w_state_n = DATA;
          w_timer_n = '0;
          w_tx_n    = r_shift[0];
        end else begin
          w_timer_n = r_timer + 1'b1;
        end
      end
      DATA: begin
        if (r_timer == TMAX) begin
          w_timer_n = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_n   = STOP;
            w_bit_idx_n = 3'd0;
            w_tx_n      = 1'b1;
          end else begin
            w_bit_idx_n = r_bit_idx + 3'd1;
            w_shift_n   = {1'b0, r_shift[7:1]};
            w_tx_n      = r_shift[1];
          end
        end else begin
          w_timer_n = r_timer + 1'b1;
        end
      end
      STOP: begin
        w_tx_n = 1'b1;
        if (r_timer == TMAX) begin
          w_state_n = IDLE;
          w_timer_n = '0;
        end else begin
          w_timer_n = r_timer + 1'b1;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_timer_n = '0;
        w_tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_mem_system.sv
// Directed bench for mips_mem_system: RAM, LED, cycle counter, unmapped space
// and UART framing including ignored writes and reset mid-frame.
module tb_mips_mem_system;

  localparam int RAM_WORDS = 256;
  localparam int CLK_DIV   = 4;

  localparam logic [31:0] A_LED   = 32'hFFFF_0000;
  localparam logic [31:0] A_CYCLE = 32'hFFFF_0004;
  localparam logic [31:0] A_TX    = 32'hFFFF_0008;
  localparam logic [31:0] A_STAT  = 32'hFFFF_000C;

  logic        clk;
  logic        rstb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data;
  logic [7:0]  leds;
  logic        uart_tx;

  int n_vec;
  int n_err;

  mips_mem_system #(
    .RAM_WORDS(RAM_WORDS),
    .CLK_DIV  (CLK_DIV)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_wr_ena (mem_wr_ena),
    .mem_rd_data(mem_rd_data),
    .leds       (leds),
    .uart_tx    (uart_tx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drivers: called at a negedge, return at the following negedge
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    mem_addr    = a;
    mem_wr_data = d;
    mem_wr_ena  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_wr_ena  = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    mem_addr = a;
    #1;
    d = mem_rd_data;
  endtask

  // Called at the negedge right after the accepting edge k.
  task automatic check_frame(input logic [7:0] data, input bit inject);
    logic exp_bit;
    logic [31:0] rd;
    for (int j = 0; j < 10 * CLK_DIV; j++) begin
      if (j < CLK_DIV)            exp_bit = 1'b0;
      else if (j < 9 * CLK_DIV)   exp_bit = data[(j - CLK_DIV) / CLK_DIV];
      else                        exp_bit = 1'b1;
      do_read(A_STAT, rd);
      check_val($sformatf("uart_tx[%0d]", j), {31'h0, uart_tx}, {31'h0, exp_bit});
      check_val($sformatf("busy[%0d]", j), rd, 32'h1);
      if (inject && j == 2 * CLK_DIV - 1) begin
        mem_addr    = A_TX;
        mem_wr_data = 32'h0000_00FF;
        mem_wr_ena  = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      mem_wr_ena = 1'b0;
    end
    do_read(A_STAT, rd);
    check_val("busy_end", rd, 32'h0);
    check_val("tx_end", {31'h0, uart_tx}, 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    n_vec       = 0;
    n_err       = 0;
    rstb        = 1'b0;
    mem_addr    = 32'h0;
    mem_wr_data = 32'h0;
    mem_wr_ena  = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check_val("rst_leds", {24'h0, leds}, 32'h0);
    check_val("rst_tx", {31'h0, uart_tx}, 32'h1);
    do_read(A_STAT, rd);
    check_val("rst_stat", rd, 32'h0);
    do_read(A_CYCLE, rd);
    check_val("rst_cycle", rd, 32'h0);

    // cycle counter
    @(negedge clk);
    rstb = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    do_read(A_CYCLE, rd);
    check_val("cycle_5", rd, 32'd5);
    @(negedge clk);
    do_write(A_CYCLE, 32'h0000_1234);
    do_read(A_CYCLE, rd);
    check_val("cycle_clr", rd, 32'd0);
    @(posedge clk);
    @(negedge clk);
    do_read(A_CYCLE, rd);
    check_val("cycle_after_clr", rd, 32'd1);

    // RAM
    do_write(32'h0000_0014, 32'h1111_2222);
    do_write(32'h0000_0000, 32'hA0A0_A0A0);
    do_write(32'h0000_0010, 32'hDEAD_BEEF);
    do_read(32'h0000_0010, rd);
    check_val("ram_10", rd, 32'hDEAD_BEEF);
    do_read(32'h0000_0013, rd);
    check_val("ram_13", rd, 32'hDEAD_BEEF);
    do_read(32'h0000_0014, rd);
    check_val("ram_14", rd, 32'h1111_2222);
    do_write(32'h0000_03FC, 32'h0BAD_F00D);
    do_read(32'h0000_03FC, rd);
    check_val("ram_top", rd, 32'h0BAD_F00D);

    // LED
    do_write(A_LED, 32'h0000_01A5);
    check_val("leds_pin", {24'h0, leds}, 32'h0000_00A5);
    do_read(A_LED, rd);
    check_val("leds_read", rd, 32'h0000_00A5);

    // unmapped space must not alias RAM, LED or the counter
    do_write(A_CYCLE, 32'h0);
    do_write(32'h0000_0400, 32'h1234_5678);
    do_write(32'h8000_0000, 32'hCAFE_F00D);
    do_read(A_CYCLE, rd);
    check_val("cycle_unmapped", rd, 32'd2);
    do_read(32'h0000_0400, rd);
    check_val("unmap_400", rd, 32'h0);
    do_read(32'h8000_0000, rd);
    check_val("unmap_8000", rd, 32'h0);
    do_read(32'hFFFF_0010, rd);
    check_val("unmap_ffff0010", rd, 32'h0);
    do_read(32'h0000_0000, rd);
    check_val("ram_0_kept", rd, 32'hA0A0_A0A0);
    check_val("leds_kept", {24'h0, leds}, 32'h0000_00A5);
    do_read(A_TX, rd);
    check_val("tx_read", rd, 32'h0);
    do_write(A_STAT, 32'hFFFF_FFFF);
    do_read(A_STAT, rd);
    check_val("stat_wr_ignored", rd, 32'h0);

    // UART frame with an ignored write at k+2*CLK_DIV
    do_write(A_TX, 32'h0000_0055);
    check_frame(8'h55, 1'b1);
    for (int j = 0; j < 2 * CLK_DIV; j++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("no_second_frame", {31'h0, uart_tx}, 32'h1);
    end

    // reset mid-frame
    do_write(A_TX, 32'h0000_00C1);
    repeat (3 * CLK_DIV - 1) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_val("tx_bit1_pre_rst", {31'h0, uart_tx}, 32'h0);
    rstb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("tx_after_rst", {31'h0, uart_tx}, 32'h1);
    do_read(A_STAT, rd);
    check_val("stat_after_rst", rd, 32'h0);
    check_val("leds_after_rst", {24'h0, leds}, 32'h0);
    rstb = 1'b1;
    @(negedge clk);
    do_write(A_TX, 32'h0000_000F);
    check_frame(8'h0F, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
